// File: rtl/saes_pkg.sv
// saes_pkg: shared S-AES FSM states, S-box, round constants and nibble helpers used by the encrypt and inverse paths
package saes_pkg;
  typedef enum logic [1:0] {IDLE, KEY, R1, R2} state_t;
  localparam logic [3:0] SBOX [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                                       4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};
  localparam logic [7:0] RCON1 = 8'h80;
  localparam logic [7:0] RCON2 = 8'h30;
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return {SBOX[b[7:4]], SBOX[b[3:0]]};
  endfunction
  function automatic logic [15:0] sub_nib(input logic [15:0] s);
    return {sub_byte(s[15:8]), sub_byte(s[7:0])};
  endfunction
  function automatic logic [7:0] rot_nib(input logic [7:0] b);
    return {b[3:0], b[7:4]};
  endfunction
  function automatic logic [15:0] shift_rows(input logic [15:0] s);
    return {s[15:12], s[3:0], s[7:4], s[11:8]};
  endfunction
endpackage

// File: rtl/saes_mixcol_fwd.sv
// saes_mixcol_fwd: combinational S-AES MixColumns [1 4; 4 1] over GF(2^4); i_d state in, o_d mixed state out
module saes_mixcol_fwd (
  input  logic [15:0] i_d,
  output logic [15:0] o_d
);
  function automatic logic [3:0] mul2(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction
  function automatic logic [3:0] mul4(input logic [3:0] a);
    return mul2(mul2(a));
  endfunction
  assign o_d = {i_d[15:12] ^ mul4(i_d[11:8]), mul4(i_d[15:12]) ^ i_d[11:8],
                i_d[7:4] ^ mul4(i_d[3:0]), mul4(i_d[7:4]) ^ i_d[3:0]};
endmodule

// File: rtl/saes_encrypt_iter.sv
// saes_encrypt_iter: iterative S-AES encryptor; clk/rst, start+pt+key in, busy, one-cycle done and held ct out
module saes_encrypt_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] pt,
  input  logic [15:0] key,
  output logic        busy,
  output logic        done,
  output logic [15:0] ct
);
  import saes_pkg::*;
  state_t r_state, w_next;
  logic [15:0] r_pt, r_key, r_k1, r_k2, r_st, r_ct;
  logic r_done;
  logic [7:0] w_w2, w_w3, w_w4, w_w5;
  logic [15:0] w_sr, w_mix;
  assign w_w2 = r_key[15:8] ^ RCON1 ^ sub_byte(rot_nib(r_key[7:0]));
  assign w_w3 = w_w2 ^ r_key[7:0];
  assign w_w4 = w_w2 ^ RCON2 ^ sub_byte(rot_nib(w_w3));
  assign w_w5 = w_w4 ^ w_w3;
  assign w_sr = shift_rows(sub_nib(r_st));
  saes_mixcol_fwd u_mix (.i_d(w_sr), .o_d(w_mix));
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    busy = r_state != IDLE;
    case (r_state)
      IDLE:    w_next = start ? KEY : IDLE;
      KEY:     w_next = R1;
      R1:      w_next = R2;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pt <= '0;
      r_key <= '0;
      r_k1 <= '0;
      r_k2 <= '0;
      r_st <= '0;
      r_ct <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= r_state == R2;
      if (r_state == IDLE && start) begin
        r_pt <= pt;
        r_key <= key;
      end
      if (r_state == KEY) begin
        r_k1 <= {w_w2, w_w3};
        r_k2 <= {w_w4, w_w5};
        r_st <= r_pt ^ r_key;
      end
      if (r_state == R1) r_st <= w_mix ^ r_k1;
      if (r_state == R2) r_ct <= w_sr ^ r_k2;
    end
  assign done = r_done;
  assign ct = r_ct;
endmodule

// File: tb/tb_saes_encrypt_iter.sv
// tb_saes_encrypt_iter: directed and randomised check of saes_encrypt_iter against a nibble-matrix S-AES model
module tb_saes_encrypt_iter;
  logic clk = 0, rst = 0, start = 0;
  logic [15:0] pt = 0, key = 0;
  logic busy, done;
  logic [15:0] ct;
  int n_vec = 0, n_err = 0, n_done = 0;
  saes_encrypt_iter dut (.clk(clk), .rst(rst), .start(start), .pt(pt), .key(key),
                         .busy(busy), .done(done), .ct(ct));
  always #5 clk = ~clk;
  logic [3:0] sb [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                          4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};
  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p = 0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p ^= a;
      a = {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction
  function automatic logic [7:0] g(input logic [7:0] b);
    return {sb[b[3:0]], sb[b[7:4]]};
  endfunction
  function automatic logic [15:0] saes_ref(input logic [15:0] p, input logic [15:0] k);
    logic [7:0] w [6];
    logic [15:0] rk [3];
    logic [3:0] n [4];
    logic [3:0] t;
    logic [15:0] s;
    w[0] = k[15:8];
    w[1] = k[7:0];
    w[2] = w[0] ^ 8'h80 ^ g(w[1]);
    w[3] = w[2] ^ w[1];
    w[4] = w[2] ^ 8'h30 ^ g(w[3]);
    w[5] = w[4] ^ w[3];
    for (int r = 0; r < 3; r++) rk[r] = {w[2*r], w[2*r+1]};
    s = p ^ rk[0];
    for (int r = 1; r <= 2; r++) begin
      for (int j = 0; j < 4; j++) n[j] = sb[s[15-4*j -: 4]];
      t = n[1]; n[1] = n[3]; n[3] = t;
      if (r == 1)
        for (int c = 0; c < 4; c += 2) begin
          t = n[c];
          n[c] = t ^ gmul(4'h4, n[c+1]);
          n[c+1] = gmul(4'h4, t) ^ n[c+1];
        end
      s = {n[0], n[1], n[2], n[3]} ^ rk[r];
    end
    return s;
  endfunction
  logic m_active = 0, m_done = 0;
  logic [15:0] m_ct = 0, m_pt = 0, m_key = 0;
  int m_age = 0;
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_active <= 0;
      m_done <= 0;
      m_ct <= 0;
      m_age <= 0;
    end else if (m_active) begin
      m_age <= m_age + 1;
      m_done <= m_age == 2;
      if (m_age == 2) begin
        m_ct <= saes_ref(m_pt, m_key);
        m_active <= 0;
      end
    end else begin
      m_done <= 0;
      if (start) begin
        m_active <= 1;
        m_age <= 0;
        m_pt <= pt;
        m_key <= key;
      end
    end
  always @(negedge clk) begin
    #1;
    if (done) n_done++;
    n_vec++;
    if ({busy, done, ct} !== {m_active, m_done, m_ct}) begin
      n_err++;
      $display("FAIL cycle t=%0t busy/done/ct got %b/%b/%h expected %b/%b/%h",
               $time, busy, done, ct, m_active, m_done, m_ct);
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input logic [15:0] p, input logic [15:0] k, input logic [15:0] e);
    int cyc, bc;
    @(negedge clk);
    start = 1; pt = p; key = k;
    @(negedge clk);
    start = 0;
    #1;
    cyc = 1;
    bc = busy ? 1 : 0;
    while (!done && cyc < 10) begin
      @(negedge clk);
      #1;
      cyc++;
      if (busy) bc++;
    end
    check("latency", cyc, 4);
    check("busy_cycles", bc, 3);
    check("ct", ct, e);
  endtask
  initial begin
    int d0;
    check("ref_pin_6F6B", saes_ref(16'h6F6B, 16'hA73B), 16'h0738);
    check("ref_pin_D728", saes_ref(16'hD728, 16'h4AF5), 16'h24EC);
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ct", ct, 0);
    rst = 0;
    run(16'h6F6B, 16'hA73B, 16'h0738);
    run(16'hD728, 16'h4AF5, 16'h24EC);
    @(negedge clk);
    d0 = n_done;
    start = 1; pt = 16'h6F6B; key = 16'hA73B;
    repeat (12) @(negedge clk);
    start = 0;
    repeat (6) @(negedge clk);
    check("hold_start_dones", n_done - d0, 3);
    check("hold_start_ct", ct, 16'h0738);
    d0 = n_done;
    start = 1; pt = 16'hD728; key = 16'h4AF5;
    @(negedge clk);
    pt = 16'h6F6B; key = 16'hA73B;
    repeat (2) @(negedge clk);
    start = 0;
    repeat (6) @(negedge clk);
    check("busy_ignore_dones", n_done - d0, 1);
    check("busy_ignore_ct", ct, 16'h24EC);
    start = 1; pt = 16'h6F6B; key = 16'hA73B;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ct", ct, 0);
    @(negedge clk);
    rst = 0;
    d0 = n_done;
    repeat (6) @(negedge clk);
    check("abort_no_done", n_done - d0, 0);
    run(16'h6F6B, 16'hA73B, 16'h0738);
    @(negedge clk);
    d0 = n_done;
    for (int i = 0; i < 4000; i++) begin
      start = 1;
      if (i % 4 != 0 || i >= 8) begin
        pt = 16'($urandom);
        key = 16'($urandom);
      end else begin
        pt = i == 0 ? 16'h0000 : 16'hFFFF;
        key = pt;
      end
      @(negedge clk);
    end
    start = 0;
    repeat (6) @(negedge clk);
    check("random_dones", n_done - d0, 1000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/saes_encrypt_iter.md
SAES_ENCRYPT_ITER -- requirements
Module: saes_encrypt_iter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by the S-AES definition (16-bit block, 16-bit key).
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset, as listed below.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request to encrypt; sampled on a clk edge only while idle.
REQ-006 pt  input  16  plaintext; captured on the accepting edge.
REQ-007 key  input  16  cipher key; captured on the accepting edge.
REQ-008 busy  output  1  high while an encryption is in progress.
REQ-009 done  output  1  one-cycle pulse when ct is valid.
REQ-010 ct  output  16  ciphertext; holds its value until the next completion.

Function
REQ-011 The FSM SHALL have states IDLE, KEY, R1 and R2; busy SHALL be 1 in every state except IDLE.
REQ-012 IDLE, start=1: the block SHALL capture pt and key, then go to KEY; start=0 keeps the FSM in IDLE.
REQ-013 KEY: the block SHALL register round keys K1 and K2, set state=pt^key (K0), then go to R1.
REQ-014 Key expansion: w0=key[15:8], w1=key[7:0], w2=w0^0x80^SubNib(RotNib(w1)), w3=w2^w1, w4=w2^0x30^SubNib(RotNib(w3)), w5=w4^w3, K1={w2,w3}, K2={w4,w5}.
REQ-015 R1: the block SHALL set state=MixCol(ShiftRows(SubNib(state)))^K1, then go to R2.
REQ-016 R2: the block SHALL set ct=ShiftRows(SubNib(state))^K2, assert done for exactly the next cycle, then return to IDLE.
REQ-017 SubNib SHALL apply, per nibble 0..F: 9,4,A,B,D,1,8,5,6,2,0,3,C,E,F,7.
REQ-018 ShiftRows SHALL swap nibbles [11:8] and [3:0]; RotNib SHALL swap the two nibbles of a byte.
REQ-019 MixCol SHALL apply matrix [1 4; 4 1] over GF(2^4) mod x^4+x+1 per column: columns are ([15:12],[11:8]) and ([7:4],[3:0]); n0'=n0^4*n1, n1'=4*n0^n1.
REQ-020 Latency SHALL be 4 cycles: with start accepted at edge E, done=1 and ct valid in the cycle after edge E+3.
REQ-021 The block SHALL ignore start while busy=1; captured inputs SHALL NOT change mid-operation.
REQ-022 In the done cycle the FSM is already IDLE, so a start in that cycle SHALL be accepted (back-to-back throughput of one block per 4 cycles).
REQ-023 pt and key changes outside the accepting edge SHALL NOT affect the result.

Reset
REQ-024 rst=1 SHALL force state IDLE, busy=0, done=0, ct=0x0000 and internal registers to 0, asynchronously.
REQ-025 Reset asserted mid-operation SHALL abort it; no done pulse SHALL follow for that operation.
REQ-026 After reset deassertion the first edge with start=1 SHALL be accepted normally.

Structure
REQ-027 A shared package saes_pkg SHALL hold the FSM state enum, the S-box table, the round constants 0x80/0x30, and functions sub_nib, rot_nib and shift_rows.
REQ-028 The forward MixColumns datapath SHALL be one sub-module, saes_mixcol_fwd (16-bit in/out, combinational, internal GF multiply-by-4); the same package and datapath style SHALL be reusable by the existing inverse path.
REQ-029 All datapath logic SHALL be single-cycle combinational between the registered stages above; no other sub-modules are required.

Verification
REQ-030 Reset, then pulse start with pt=0x6F6B, key=0xA73B -> done pulse 4 cycles later with ct=0x0738; busy=1 for exactly 3 cycles before it.
REQ-031 start with pt=0xD728, key=0x4AF5 -> ct=0x24EC.
REQ-032 Hold start=1 for 12 cycles with pt/key fixed at 0x6F6B/0xA73B -> three done pulses 4 cycles apart, each with ct=0x0738.
REQ-033 Pulse start, then change pt/key and pulse start again during busy -> ct reflects the first inputs only, and exactly one done pulse occurs.
REQ-034 Assert rst during R1 -> busy=0, ct=0x0000 immediately, and no done pulse follows; a new start then completes correctly.
REQ-035 Compare 1000 random pt/key pairs against a reference S-AES model, including all-zero and all-ones inputs -> ct matches on every done pulse.
